// File: rtl/ap_ddr_pkg.sv
// Shared definitions for the DDR read arbiter: state encoding, requester IDs
// and default widths.
package ap_ddr_pkg;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_LEN_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic REQ_ISA = 1'b0;
    localparam logic REQ_DAT = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant register resets to DATA so ISA
// wins the first tie.
module rr_arb2
    import ap_ddr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       any,
    output logic       pick
);

    logic last;

    always_comb begin
        any  = req[REQ_ISA] | req[REQ_DAT];
        pick = REQ_ISA;
        if (req[REQ_ISA] && req[REQ_DAT]) begin
            pick = ~last;
        end else if (req[REQ_DAT]) begin
            pick = REQ_DAT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= REQ_DAT;
        end else if (take && any) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Shares the DDR burst-read port between the instruction refill path and the
// data load path; one burst per grant, beats steered to the owner only.
//
// state | meaning
// IDLE  | waiting for a request; beats from DDR ignored
// BURST | rd_burst_req high, forwarding beats to owner until finish
// DONE  | owner's done pulse (zero-length grants spend one extra cycle here)
module ddr_rd_arbiter
    import ap_ddr_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = ap_ddr_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = ap_ddr_pkg::DEF_DATA_WIDTH,
    parameter int LEN_WIDTH      = ap_ddr_pkg::DEF_LEN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      isa_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
    input  logic [LEN_WIDTH-1:0]      isa_len,
    output logic                      isa_rd_valid,
    output logic [DATA_WIDTH-1:0]     isa_rd_data,
    output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
    output logic                      isa_done,

    input  logic                      dat_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dat_addr,
    input  logic [LEN_WIDTH-1:0]      dat_len,
    output logic                      dat_rd_valid,
    output logic [DATA_WIDTH-1:0]     dat_rd_data,
    output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
    output logic                      dat_done,

    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic                      rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0]     rd_burst_data,
    input  logic                      rd_burst_finish,

    output logic                      busy
);

    state_t                   state;
    logic                     owner;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     cnt;

    logic                     any;
    logic                     pick;
    logic                     take;
    logic [DDR_ADDR_WIDTH-1:0] g_addr;
    logic [LEN_WIDTH-1:0]     g_len;

    assign take = (state == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rst  (rst),
        .req  ({dat_req, isa_req}),
        .take (take),
        .any  (any),
        .pick (pick)
    );

    always_comb begin
        g_addr = isa_addr;
        g_len  = isa_len;
        if (pick == REQ_DAT) begin
            g_addr = dat_addr;
            g_len  = dat_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= REQ_ISA;
            len_q         <= '0;
            cnt           <= '0;
            rd_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            rd_burst_len  <= '0;
            isa_rd_valid  <= 1'b0;
            isa_rd_data   <= '0;
            isa_rd_cnt    <= '0;
            isa_done      <= 1'b0;
            dat_rd_valid  <= 1'b0;
            dat_rd_data   <= '0;
            dat_rd_cnt    <= '0;
            dat_done      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            isa_rd_valid <= 1'b0;
            dat_rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner      <= pick;
                        len_q      <= g_len;
                        cnt        <= '0;
                        isa_rd_cnt <= '0;
                        dat_rd_cnt <= '0;
                        busy       <= 1'b1;
                        if (g_len != '0) begin
                            state         <= BURST;
                            rd_burst_req  <= 1'b1;
                            rd_burst_addr <= g_addr;
                            rd_burst_len  <= g_len;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                BURST: begin
                    // Beats past the latched length are dropped; cnt saturates at len.
                    if (rd_burst_data_valid && (cnt < len_q)) begin
                        cnt <= cnt + 1'b1;
                        if (owner == REQ_ISA) begin
                            isa_rd_valid <= 1'b1;
                            isa_rd_data  <= rd_burst_data;
                            isa_rd_cnt   <= cnt + 1'b1;
                        end else begin
                            dat_rd_valid <= 1'b1;
                            dat_rd_data  <= rd_burst_data;
                            dat_rd_cnt   <= cnt + 1'b1;
                        end
                    end
                    if (rd_burst_finish) begin
                        state        <= DONE;
                        rd_burst_req <= 1'b0;
                        if (owner == REQ_ISA) begin
                            isa_done <= 1'b1;
                        end else begin
                            dat_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Arriving from IDLE (zero length) the pulse is not yet up.
                    if (isa_done || dat_done) begin
                        isa_done <= 1'b0;
                        dat_done <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (owner == REQ_ISA) begin
                        isa_done <= 1'b1;
                    end else begin
                        dat_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter with a beat scoreboard checked on the
// falling clock edge.
module tb_ddr_rd_arbiter;

    localparam int AW = 28;
    localparam int DW = 64;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          isa_req, dat_req;
    logic [AW-1:0] isa_addr, dat_addr;
    logic [LW-1:0] isa_len, dat_len;
    logic          isa_rd_valid, dat_rd_valid;
    logic [DW-1:0] isa_rd_data, dat_rd_data;
    logic [LW-1:0] isa_rd_cnt, dat_rd_cnt;
    logic          isa_done, dat_done;
    logic          rd_burst_req;
    logic [AW-1:0] rd_burst_addr;
    logic [LW-1:0] rd_burst_len;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_finish;
    logic          busy;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] data;
        logic [LW-1:0] cnt;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    vecs = 0;
    int    errs = 0;

    always #5 clk = ~clk;

    ddr_rd_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .isa_req             (isa_req),
        .isa_addr            (isa_addr),
        .isa_len             (isa_len),
        .isa_rd_valid        (isa_rd_valid),
        .isa_rd_data         (isa_rd_data),
        .isa_rd_cnt          (isa_rd_cnt),
        .isa_done            (isa_done),
        .dat_req             (dat_req),
        .dat_addr            (dat_addr),
        .dat_len             (dat_len),
        .dat_rd_valid        (dat_rd_valid),
        .dat_rd_data         (dat_rd_data),
        .dat_rd_cnt          (dat_rd_cnt),
        .dat_done            (dat_done),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .busy                (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Forwarded beats must match the scoreboard head, on the owner's port only.
    always @(negedge clk) begin
        if (isa_rd_valid || dat_rd_valid) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $error("FAIL unexpected_beat: isa_v %0b dat_v %0b, expected no beat",
                       isa_rd_valid, dat_rd_valid);
            end else begin
                mon_b = exp_q.pop_front();
                chk("beat_isa_valid", {63'd0, isa_rd_valid}, {63'd0, mon_b.owner == 1'b0});
                chk("beat_dat_valid", {63'd0, dat_rd_valid}, {63'd0, mon_b.owner == 1'b1});
                chk("beat_data", mon_b.owner ? dat_rd_data : isa_rd_data, mon_b.data);
                chk("beat_cnt", {54'd0, mon_b.owner ? dat_rd_cnt : isa_rd_cnt}, {54'd0, mon_b.cnt});
            end
        end
    end

    // Entered on the falling edge where rd_burst_req is first high; leaves on
    // the falling edge one cycle after finish (done visible).
    task automatic serve(input logic owner, input logic [LW-1:0] len,
                         input int nbeats, input bit fin_last);
        beat_t         b;
        logic [DW-1:0] d;
        for (int i = 1; i <= nbeats; i++) begin
            d = {$urandom, $urandom};
            rd_burst_data_valid = 1'b1;
            rd_burst_data       = d;
            if (i <= int'(len)) begin
                b.owner = owner;
                b.data  = d;
                b.cnt   = LW'(i);
                exp_q.push_back(b);
            end
            if (fin_last && i == nbeats) rd_burst_finish = 1'b1;
            tick();
        end
        rd_burst_data_valid = 1'b0;
        if (!fin_last) begin
            rd_burst_finish = 1'b1;
            tick();
        end
        rd_burst_finish = 1'b0;
        chk("fin_breq_low", {63'd0, rd_burst_req}, 64'd0);
        chk("fin_owner_done", {63'd0, owner ? dat_done : isa_done}, 64'd1);
        chk("fin_other_done", {63'd0, owner ? isa_done : dat_done}, 64'd0);
        chk("fin_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {62'd0, isa_done, dat_done}, 64'd0);
    endtask

    task automatic chk_grant(input string tag, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        chk({tag, "_breq"}, {63'd0, rd_burst_req}, 64'd1);
        chk({tag, "_addr"}, {36'd0, rd_burst_addr}, {36'd0, addr});
        chk({tag, "_len"}, {54'd0, rd_burst_len}, {54'd0, len});
    endtask

    initial begin
        rst = 1'b0;
        isa_req = 1'b0; isa_addr = '0; isa_len = '0;
        dat_req = 1'b0; dat_addr = '0; dat_len = '0;
        rd_burst_data_valid = 1'b0; rd_burst_data = '0; rd_burst_finish = 1'b0;
        tick(); tick();
        chk("rst_breq", {63'd0, rd_burst_req}, 64'd0);
        chk("rst_baddr", {36'd0, rd_burst_addr}, 64'd0);
        chk("rst_blen", {54'd0, rd_burst_len}, 64'd0);
        chk("rst_valid", {62'd0, isa_rd_valid, dat_rd_valid}, 64'd0);
        chk("rst_cnt", {44'd0, isa_rd_cnt, dat_rd_cnt}, 64'd0);
        chk_idle("rst");
        rst = 1'b1;
        tick();

        // Simultaneous pair after reset: ISA first, DATA next at f+3.
        isa_req = 1'b1; isa_addr = 28'h100; isa_len = 10'd2;
        dat_req = 1'b1; dat_addr = 28'h200; dat_len = 10'd2;
        tick();
        chk_grant("tie1_isa", 28'h100, 10'd2);
        chk("tie1_busy", {63'd0, busy}, 64'd1);
        serve(1'b0, 10'd2, 2, 1'b0);
        isa_req = 1'b0;
        tick();
        chk_idle("tie1_f2");
        tick();
        chk_grant("tie1_dat", 28'h200, 10'd2);
        serve(1'b1, 10'd2, 2, 1'b0);
        dat_req = 1'b0;
        tick();
        chk_idle("tie1_end");

        // Single ISA refill of four beats.
        isa_req = 1'b1; isa_addr = 28'h000_0400; isa_len = 10'd4;
        tick();
        chk_grant("isa4", 28'h400, 10'd4);
        serve(1'b0, 10'd4, 4, 1'b0);
        isa_req = 1'b0;
        tick();
        chk_idle("isa4_end");

        // Second pair: ISA was last, so DATA wins; finish lands with last beat.
        isa_req = 1'b1; isa_addr = 28'hC00; isa_len = 10'd3;
        dat_req = 1'b1; dat_addr = 28'h800; dat_len = 10'd3;
        tick();
        chk_grant("tie2_dat", 28'h800, 10'd3);
        serve(1'b1, 10'd3, 3, 1'b1);
        dat_req = 1'b0;
        tick();
        chk_idle("tie2_f2");
        tick();
        chk_grant("tie2_isa", 28'hC00, 10'd3);
        serve(1'b0, 10'd3, 3, 1'b0);
        isa_req = 1'b0;
        tick();

        // Zero-length DATA request: done at N+2, no DDR request.
        dat_req = 1'b1; dat_addr = 28'h123; dat_len = 10'd0;
        tick();
        chk("len0_n1_breq", {63'd0, rd_burst_req}, 64'd0);
        chk("len0_n1_done", {63'd0, dat_done}, 64'd0);
        chk("len0_n1_busy", {63'd0, busy}, 64'd1);
        dat_req = 1'b0;
        tick();
        chk("len0_n2_done", {63'd0, dat_done}, 64'd1);
        chk("len0_n2_isa_done", {63'd0, isa_done}, 64'd0);
        chk("len0_n2_breq", {63'd0, rd_burst_req}, 64'd0);
        tick();
        chk_idle("len0_n3");

        // Overrun: six beats for len 4.
        isa_req = 1'b1; isa_addr = 28'h40; isa_len = 10'd4;
        tick();
        chk_grant("ovr", 28'h40, 10'd4);
        serve(1'b0, 10'd4, 6, 1'b0);
        chk("ovr_cnt_hold", {54'd0, isa_rd_cnt}, 64'd4);
        isa_req = 1'b0;
        tick();
        chk_idle("ovr_end");

        // Reset during beat 2 of an 8-beat burst.
        isa_req = 1'b1; isa_addr = 28'h3000; isa_len = 10'd8;
        tick();
        chk_grant("rstm", 28'h3000, 10'd8);
        begin
            beat_t b;
            b.owner = 1'b0; b.data = 64'hA5A5_0001_DEAD_BEEF; b.cnt = 10'd1;
            rd_burst_data_valid = 1'b1; rd_burst_data = b.data;
            exp_q.push_back(b);
        end
        tick();
        rd_burst_data = 64'h0BAD_0BAD_0BAD_0BAD;
        #2 rst = 1'b0;
        isa_req = 1'b0;
        tick();
        chk("rstm_breq", {63'd0, rd_burst_req}, 64'd0);
        chk("rstm_baddr", {36'd0, rd_burst_addr}, 64'd0);
        chk("rstm_valid", {62'd0, isa_rd_valid, dat_rd_valid}, 64'd0);
        chk("rstm_data", isa_rd_data, 64'd0);
        chk("rstm_cnt", {54'd0, isa_rd_cnt}, 64'd0);
        chk_idle("rstm");
        rst = 1'b1;
        rd_burst_finish = 1'b1;
        tick();
        rd_burst_finish = 1'b0;
        tick(); tick();
        rd_burst_data_valid = 1'b0;
        chk("rstm_stray_breq", {63'd0, rd_burst_req}, 64'd0);
        isa_req = 1'b1; isa_addr = 28'h5000; isa_len = 10'd2;
        tick();
        chk_grant("rstm_new", 28'h5000, 10'd2);
        serve(1'b0, 10'd2, 2, 1'b0);
        isa_req = 1'b0;
        tick();

        // DATA request held through done: re-granted with rd_burst_req at f+3.
        dat_req = 1'b1; dat_addr = 28'h6000; dat_len = 10'd2;
        tick();
        chk_grant("held1", 28'h6000, 10'd2);
        serve(1'b1, 10'd2, 2, 1'b0);
        tick();
        chk("held_f2_breq", {63'd0, rd_burst_req}, 64'd0);
        chk("held_f2_done", {63'd0, dat_done}, 64'd0);
        tick();
        chk_grant("held2", 28'h6000, 10'd2);
        serve(1'b1, 10'd2, 2, 1'b0);
        dat_req = 1'b0;
        tick();
        chk_idle("held_end");

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Two-requester read arbiter that shares the single DDR burst-read port between the instruction cache refill path and the data load path. It latches one requester's address and length, issues one DDR burst, and steers the returned beats and beat count back to the granted requester only. It signals completion with a one-cycle done pulse. It sits between the instruction cache / data cache and the DDR interface module.

## Interface
- DDR_ADDR_WIDTH, 28, DDR byte address width
- DATA_WIDTH, 64, DDR read beat width
- LEN_WIDTH, 10, burst length and beat count width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- isa_req  in  1  instruction refill request; held high until isa_done
- isa_addr  in  DDR_ADDR_WIDTH  refill start address; sampled at grant
- isa_len  in  LEN_WIDTH  refill beats; sampled at grant
- isa_rd_valid  out  1  beat valid to instruction cache
- isa_rd_data  out  DATA_WIDTH  beat data
- isa_rd_cnt  out  LEN_WIDTH  1-based index of current beat
- isa_done  out  1  one-cycle completion pulse
- dat_req / dat_addr / dat_len / dat_rd_valid / dat_rd_data / dat_rd_cnt / dat_done: same directions, widths and meanings for the data load path
- rd_burst_req  out  1  burst request to DDR interface
- rd_burst_addr  out  DDR_ADDR_WIDTH  burst address
- rd_burst_len  out  LEN_WIDTH  burst length
- rd_burst_data_valid  in  1  DDR beat valid
- rd_burst_data  in  DATA_WIDTH  DDR beat data
- rd_burst_finish  in  1  DDR burst complete pulse
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, BURST, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that was NOT granted last (round-robin). After reset, last grant = DATA, so ISA wins the first tie.
  - On grant: latch addr/len, record grant owner, clear the beat counter.
  - Granted len ≠ 0: go to BURST.
  - Granted len = 0: go straight to DONE. No DDR request is issued.
- BURST:
  - rd_burst_req = 1, driven from the latched addr/len; held high until rd_burst_finish.
  - Each rd_burst_data_valid increments the beat counter.
  - Counter ≤ latched len: forward the beat to the owner only.
  - Counter > latched len: drop the beat; the counter saturates at len.
  - The non-owner's rd_valid stays 0 throughout.
  - rd_burst_finish: go to DONE. A beat arriving in the same cycle as finish is still forwarded.
- DONE:
  - Owner's done = 1 for exactly one cycle, then return to IDLE.
  - The owner must drop req by the IDLE cycle. A req still high there is treated as a new request.
- Requests arriving while busy are held off. A req that drops before grant is lost without error.
- Reset mid-burst: return to IDLE, all outputs to 0. DDR beats still in flight are ignored while in IDLE.
- Arithmetic: the beat counter is LEN_WIDTH unsigned. rd_burst_addr passes through unmodified; any ×8 scaling is the requester's responsibility.

## Timing
- Reset values:
  - state = IDLE, last grant = DATA.
  - rd_burst_req, rd_burst_addr, rd_burst_len = 0.
  - All rd_valid, rd_data, rd_cnt, done, busy = 0.
- Grant latency: req high in IDLE at cycle N → rd_burst_req high at N+1.
- Beat latency: rd_burst_data_valid at cycle k → owner rd_valid, rd_data and rd_cnt updated at k+1 (registered).
- Completion: rd_burst_finish at cycle f → rd_burst_req low at f+1, done high at f+1, IDLE at f+2.
- Back-to-back: the earliest next grant is sampled at f+2, so the next rd_burst_req rises at f+3.
- len = 0: req at N → done at N+2, rd_burst_req never asserted.

## Structure
- Shared package ap_ddr_pkg holds:
  - State encodings IDLE/BURST/DONE.
  - Requester ID constants REQ_ISA = 1'b0, REQ_DAT = 1'b1.
  - Default DDR_ADDR_WIDTH and LEN_WIDTH.
- One sub-module: rr_arb2, a 2-way round-robin picker with last-grant register.
- The requester ports and the data mux stay in the top module.

## Test plan
- isa_req, addr 0x000_0400, len 4; DDR returns 4 beats then finish → rd_burst_req at N+1 with addr 0x400, len 4; isa_rd_cnt 1..4; one isa_done; dat_rd_valid stays 0.
- isa_req and dat_req rise together, both len 2 → ISA served first, then DATA; a second simultaneous pair → DATA served first.
- dat_req with len 0 → dat_done at N+2; rd_burst_req never high.
- DDR returns 6 beats for len 4 → only 4 forwarded; rd_cnt stops at 4; done on finish.
- rst low during beat 2 of an 8-beat burst → all outputs 0 next edge; stray beats after reset release produce no rd_valid; a new isa_req is then granted normally.
- dat_req held through its dat_done → a second DATA burst is granted with rd_burst_req rising at f+3.
